// File: rtl/fourbit_bitset_arbiter_pkg.sv
// Shared types and constants for the 4-bit bit-set arbiter.
// Holds the FSM state encodings, register width and the single-bit update function.
package fourbit_bitset_arbiter_pkg;

    localparam int unsigned REG_W = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    // Returns data with exactly one bit replaced; every write path uses this.
    function automatic logic [REG_W-1:0] bitset(
        input logic [REG_W-1:0] data,
        input logic [IDX_W-1:0] index,
        input logic             value
    );
        logic [REG_W-1:0] result;
        result        = data;
        result[index] = value;
        return result;
    endfunction

endpackage

// File: rtl/fourbit_bitset_arbiter_bitset.sv
// Single-bit update datapath: replaces bit index_i of data_i with value_i.
module fourbit_bitset_arbiter_bitset
    import fourbit_bitset_arbiter_pkg::*;
(
    input  logic [REG_W-1:0] data_i,
    input  logic [IDX_W-1:0] index_i,
    input  logic             value_i,
    output logic [REG_W-1:0] data_o
);

    assign data_o = bitset(data_i, index_i, value_i);

endmodule

// File: rtl/fourbit_bitset_arbiter.sv
// Two-requester round-robin bit-set arbiter with a 4-cycle sequential fill (sweep).
//   state    | meaning
//   ST_IDLE  | serve one requester per cycle, or accept a sweep_start
//   ST_SWEEP | write latched fill value to bits 0..3, one per cycle
module fourbit_bitset_arbiter
    import fourbit_bitset_arbiter_pkg::*;
#(
    parameter logic [REG_W-1:0] RESET_VALUE = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [IDX_W-1:0] index_a,
    input  logic             value_a,
    input  logic             req_b,
    input  logic [IDX_W-1:0] index_b,
    input  logic             value_b,
    input  logic             sweep_start,
    input  logic             sweep_value,
    output logic             grant_a,
    output logic             grant_b,
    output logic [REG_W-1:0] reg_q,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             sweep_val_q, sweep_val_d;
    logic             last_b_q, last_b_d;
    logic             done_q, done_d;
    logic [REG_W-1:0] reg_d;

    logic             grant_a_d, grant_b_d;
    logic             wr_en;
    logic [IDX_W-1:0] wr_index;
    logic             wr_value;
    logic [REG_W-1:0] set_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sweep_val_d = sweep_val_q;
        last_b_d    = last_b_q;
        done_d      = 1'b0;
        grant_a_d   = 1'b0;
        grant_b_d   = 1'b0;
        wr_en       = 1'b0;
        wr_index    = cnt_q;
        wr_value    = sweep_val_q;

        if (state_q == ST_IDLE) begin
            if (sweep_start) begin
                state_d     = ST_SWEEP;
                cnt_d       = '0;
                sweep_val_d = sweep_value;
            end else if (req_a && (!req_b || last_b_q)) begin
                // last_b_q set means B won last, so A gets the tie
                grant_a_d = 1'b1;
                wr_en     = 1'b1;
                wr_index  = index_a;
                wr_value  = value_a;
                last_b_d  = 1'b0;
            end else if (req_b) begin
                grant_b_d = 1'b1;
                wr_en     = 1'b1;
                wr_index  = index_b;
                wr_value  = value_b;
                last_b_d  = 1'b1;
            end
        end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    fourbit_bitset_arbiter_bitset u_fourbit_bitset (
        .data_i  (reg_q),
        .index_i (wr_index),
        .value_i (wr_value),
        .data_o  (set_data)
    );

    assign reg_d = wr_en ? set_data : reg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sweep_val_q <= 1'b0;
            last_b_q    <= 1'b1;
            done_q      <= 1'b0;
            reg_q       <= RESET_VALUE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sweep_val_q <= sweep_val_d;
            last_b_q    <= last_b_d;
            done_q      <= done_d;
            reg_q       <= reg_d;
        end
    end

    // Grants are combinational, so they must be gated directly by reset.
    assign grant_a = grant_a_d & rst_n;
    assign grant_b = grant_b_d & rst_n;
    assign busy    = (state_q == ST_SWEEP);
    assign done    = done_q;

endmodule
